// File: rtl/q2_pkg.sv
// Shared width, count type and reset value for the q2 loadable counter.
package q2_pkg;

    localparam int Q2_WIDTH = 4;

    typedef logic [Q2_WIDTH-1:0] q2_cnt_t;

    localparam q2_cnt_t Q2_RST_VAL = '0;

endpackage

// File: rtl/q2_gray_enc.sv
// Combinational binary-to-Gray converter.
// Used by q2 only when Q2_GRAY_OUT_EN is defined.
module q2_gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/q2.sv
// 4-bit loadable wrap-around up-counter with a registered output.
// When Q2_GRAY_OUT_EN is defined, out carries the Gray code of the count.
module q2
    import q2_pkg::*;
#(
    parameter int WIDTH = Q2_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic [WIDTH-1:0] init,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // A load takes priority over the increment, so a load on the wrap cycle wins.
    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (set) begin
            cnt_d = init;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= WIDTH'(Q2_RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef Q2_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_d;
    logic [WIDTH-1:0] out_q;

    q2_gray_enc #(
        .WIDTH (WIDTH)
    ) u_gray_enc (
        .bin_i  (cnt_d),
        .gray_o (gray_d)
    );

    // Encoding the next count keeps the output latency at one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= WIDTH'(Q2_RST_VAL);
        end else begin
            out_q <= gray_d;
        end
    end

    assign out = out_q;
`else
    assign out = cnt_q;
`endif

endmodule

// File: tb/tb_q2.sv
// Self-checking bench for q2: directed scenarios plus random set/init traffic
// against a reference model of the counter's arithmetic rules.
module tb_q2;

    logic       clk;
    logic       reset;
    logic       set;
    logic [3:0] init;
    logic [3:0] out;

    int checkCount;
    int failCount;
    int expCnt;

    q2 dut (
        .clk   (clk),
        .reset (reset),
        .set   (set),
        .init  (init),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] expOut(input int cnt);
        int v;
        v = cnt % 16;
`ifdef Q2_GRAY_OUT_EN
        v = v ^ (v / 2);
`endif
        return 4'(v);
    endfunction

    task automatic checkOutput(input string tag);
        logic [3:0] expected;
        expected = expOut(expCnt);
        checkCount++;
        assert (out === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, out, expected);
        end
    endtask

    // Drives set/init, lets one rising edge pass, advances the model, then checks.
    task automatic applyStimulus(input logic s, input logic [3:0] i, input string tag);
        set  = s;
        init = i;
        @(posedge clk);
        #1;
        if (!reset) begin
            expCnt = 0;
        end else if (s) begin
            expCnt = int'(i);
        end else begin
            expCnt = (expCnt + 1) % 16;
        end
        checkOutput(tag);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        expCnt     = 0;
        reset      = 1'b0;
        set        = 1'b1;
        init       = 4'h9;

        // Reset held low for 100 ns while a load is requested.
        #1;
        checkOutput("reset_initial");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 4'h9, "reset_hold");
        end

        // Release, then free-run through the wrap: 1..15, 0, 1.
        reset = 1'b1;
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b0, 4'h0, "free_run");
        end

        applyStimulus(1'b1, 4'hA, "load_a");
        applyStimulus(1'b0, 4'h0, "load_a_plus1");
        applyStimulus(1'b0, 4'h0, "load_a_plus2");

        applyStimulus(1'b1, 4'hE, "preload_e");
        applyStimulus(1'b0, 4'h0, "reach_f");
        applyStimulus(1'b1, 4'h3, "load_on_wrap");

        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 4'(k), "stream_load");
        end

        // Asynchronous clear mid-cycle from a count of 5.
        applyStimulus(1'b1, 4'h5, "load_5");
        #2;
        reset  = 1'b0;
        expCnt = 0;
        #1;
        checkOutput("async_clear");

        // Release with set high: the first edge loads init.
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 4'h6, "release_load");

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2;
                reset  = 1'b0;
                expCnt = 0;
                #1;
                checkOutput("rand_async_clear");
                #1;
                reset = 1'b1;
            end
            applyStimulus(1'($urandom_range(0, 3) == 0), 4'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
